// File: rtl/aref_debt_scheduler_pkg.sv
// Shared softMC definitions used by the auto-refresh debt scheduler:
// FSM state encoding and default postponement / pull-in / debt sizing.
package aref_debt_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_URGENT = 2'd2
   } aref_state_t;

   localparam int AREF_MAX_POSTPONE = 8;
   localparam int AREF_MAX_PULLIN   = 8;
   localparam int AREF_DEBT_WIDTH   = 5;

endpackage

// File: rtl/aref_interval_timer.sv
// Reloadable tREFI down-counter: emits a registered one-cycle tick every
// i_interval cycles while enabled; held at its reload value otherwise.
module aref_interval_timer
   import aref_debt_scheduler_pkg::*;
#(
   parameter int INTERVAL_WIDTH = 28
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_enable,
   input  logic [INTERVAL_WIDTH-1:0] i_interval,
   output logic                      o_tick
);

   logic [INTERVAL_WIDTH-1:0] r_cnt;
   logic                      r_run;
   logic                      r_tick;
   logic [INTERVAL_WIDTH-1:0] w_reload;
   logic [INTERVAL_WIDTH-1:0] w_cur;

   assign w_reload = i_interval - INTERVAL_WIDTH'(1);
   // Until the first enabled cycle the count is taken straight from the reload value.
   assign w_cur    = r_run ? r_cnt : w_reload;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_tick <= 1'b0;
      end else if (!i_enable) begin
         r_cnt  <= w_reload;
         r_run  <= 1'b0;
         r_tick <= 1'b0;
      end else if (w_cur == '0) begin
         r_cnt  <= w_reload;
         r_run  <= 1'b1;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= w_cur - INTERVAL_WIDTH'(1);
         r_run  <= 1'b1;
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/aref_debt_scheduler.sv
// Auto-refresh debt scheduler: accrues refresh credits, issues opportunistic
// or forced requests. Define AREF_PULLIN_EN to enable idle-time pull-in.
module aref_debt_scheduler
   import aref_debt_scheduler_pkg::*;
#(
   parameter int INTERVAL_WIDTH = 28,
   parameter int MAX_POSTPONE   = AREF_MAX_POSTPONE,
`ifdef AREF_PULLIN_EN
   parameter int MAX_PULLIN     = AREF_MAX_PULLIN,
   parameter int PULLIN_IDLE    = 64,
`endif
   parameter int DEBT_WIDTH     = AREF_DEBT_WIDTH
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_aref_en,
   input  logic [INTERVAL_WIDTH-1:0] i_aref_interval,
   input  logic                      i_dispatcher_busy,
   input  logic                      i_host_pending,
   output logic                      o_autoref_req,
   input  logic                      i_autoref_ack,
   output logic                      o_aref_urgent,
   output logic [DEBT_WIDTH-1:0]     o_aref_debt,
   output logic                      o_aref_overflow
);

   localparam logic signed [DEBT_WIDTH-1:0] DEBT_ZERO   = DEBT_WIDTH'(0);
   localparam logic signed [DEBT_WIDTH-1:0] DEBT_ONE    = DEBT_WIDTH'(1);
   localparam logic signed [DEBT_WIDTH-1:0] DEBT_URGENT = DEBT_WIDTH'(MAX_POSTPONE);
   localparam logic signed [DEBT_WIDTH-1:0] DEBT_SAT    = DEBT_WIDTH'(MAX_POSTPONE + 1);

   aref_state_t                   r_state;
   aref_state_t                   w_state_nxt;
   logic signed [DEBT_WIDTH-1:0]  r_debt;
   logic                          r_overflow;
   logic                          r_req;
   logic                          r_urgent;
   logic                          w_enabled;
   logic                          w_tick;
   logic                          w_ack;
   logic                          w_idle;

   assign w_enabled = i_aref_en && (i_aref_interval != '0);
   assign w_ack     = i_autoref_ack && r_req;
   assign w_idle    = !i_dispatcher_busy && !i_host_pending;

   aref_interval_timer #(
      .INTERVAL_WIDTH (INTERVAL_WIDTH)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_enable   (w_enabled),
      .i_interval (i_aref_interval),
      .o_tick     (w_tick)
   );

`ifdef AREF_PULLIN_EN
   localparam logic signed [DEBT_WIDTH-1:0] DEBT_FLOOR = DEBT_WIDTH'(-MAX_PULLIN);
   localparam int                           IDLE_W     = $clog2(PULLIN_IDLE + 1);
   localparam logic [IDLE_W-1:0]            IDLE_SAT   = IDLE_W'(PULLIN_IDLE);

   logic [IDLE_W-1:0] r_idle_cnt;

   // Consecutive idle-cycle counter, saturating at the pull-in threshold.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idle_cnt <= '0;
      end else if (!w_idle) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != IDLE_SAT) begin
         r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end
   end
`endif

   // Debt accounting and sticky overflow flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_debt     <= DEBT_ZERO;
         r_overflow <= 1'b0;
      end else if (!w_enabled) begin
         r_debt <= DEBT_ZERO;
      end else if (w_tick && !w_ack) begin
         if (r_debt == DEBT_SAT) begin
            r_overflow <= 1'b1;
         end else begin
            r_debt <= r_debt + DEBT_ONE;
         end
      end else if (w_ack && !w_tick) begin
`ifdef AREF_PULLIN_EN
         r_debt <= r_debt - DEBT_ONE;
`else
         if (r_debt > DEBT_ZERO) begin
            r_debt <= r_debt - DEBT_ONE;
         end
`endif
      end
   end

   // Request FSM next-state logic; requests are only released by an ack.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_enabled) begin
               w_state_nxt = ST_IDLE;
            end else if (r_debt >= DEBT_URGENT) begin
               w_state_nxt = ST_URGENT;
            end else if ((r_debt > DEBT_ZERO) && w_idle) begin
               w_state_nxt = ST_REQ;
`ifdef AREF_PULLIN_EN
            end else if ((r_debt <= DEBT_ZERO) && (r_debt > DEBT_FLOOR) &&
                         (r_idle_cnt == IDLE_SAT)) begin
               w_state_nxt = ST_REQ;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (w_ack) begin
               w_state_nxt = ST_IDLE;
            end else if (w_enabled && (r_debt >= DEBT_URGENT)) begin
               w_state_nxt = ST_URGENT;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_URGENT: begin
            if (w_ack) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_URGENT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register with request/urgent outputs registered from the next state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_req    <= 1'b0;
         r_urgent <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_req    <= (w_state_nxt != ST_IDLE);
         r_urgent <= (w_state_nxt == ST_URGENT);
      end
   end

   assign o_autoref_req   = r_req;
   assign o_aref_urgent   = r_urgent;
   assign o_aref_debt     = r_debt;
   assign o_aref_overflow = r_overflow;

endmodule

// File: tb/tb_aref_debt_scheduler.sv
// Self-checking bench for aref_debt_scheduler: directed scenarios plus random
// stimulus, all checked every cycle against a behavioural model.
module tb_aref_debt_scheduler;

   localparam int MP  = 8;
   localparam int MPI = 8;
   localparam int PI  = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        aref_en = 1'b0;
   logic [27:0] aref_interval = 28'd0;
   logic        dispatcher_busy = 1'b0;
   logic        host_pending = 1'b0;
   logic        autoref_ack = 1'b0;
   logic        autoref_req;
   logic        aref_urgent;
   logic [4:0]  aref_debt;
   logic        aref_overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state: the values the outputs should show this cycle.
   int m_debt;
   bit m_req, m_urg, m_ovf;
   int m_idle;
   int m_start;
   int m_n;

   always #5 clk = ~clk;

   aref_debt_scheduler dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_aref_en         (aref_en),
      .i_aref_interval   (aref_interval),
      .i_dispatcher_busy (dispatcher_busy),
      .i_host_pending    (host_pending),
      .o_autoref_req     (autoref_req),
      .i_autoref_ack     (autoref_ack),
      .o_aref_urgent     (aref_urgent),
      .o_aref_debt       (aref_debt),
      .o_aref_overflow   (aref_overflow)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_debt  = 0;
      m_req   = 1'b0;
      m_urg   = 1'b0;
      m_ovf   = 1'b0;
      m_idle  = 0;
      m_start = -1;
      m_n     = 1;
   endtask

   // Ticks fall at start+N, start+2N, ... where start is the first enabled cycle.
   task automatic model_step();
      bit en, tick, ack_eff, idle, nreq, nurg;
      int nd;
      en      = aref_en && (aref_interval != 28'd0);
      tick    = (m_start >= 0) && (cyc > m_start) && (((cyc - m_start) % m_n) == 0);
      ack_eff = autoref_ack && m_req;
      idle    = !dispatcher_busy && !host_pending;

      nd = m_debt;
      if (!en) nd = 0;
      else if (tick && !ack_eff) begin
         if (m_debt == MP + 1) m_ovf = 1'b1;
         else nd = m_debt + 1;
      end else if (ack_eff && !tick) begin
`ifdef AREF_PULLIN_EN
         nd = m_debt - 1;
`else
         nd = (m_debt > 0) ? m_debt - 1 : m_debt;
`endif
      end

      nreq = m_req;
      nurg = m_urg;
      if (ack_eff) begin
         nreq = 1'b0;
         nurg = 1'b0;
      end else if (!m_req) begin
         if (en && m_debt >= MP) begin
            nreq = 1'b1;
            nurg = 1'b1;
         end else if (en && m_debt > 0 && idle) nreq = 1'b1;
`ifdef AREF_PULLIN_EN
         else if (en && m_debt <= 0 && m_debt > -MPI && m_idle == PI) nreq = 1'b1;
`endif
      end else if (!m_urg && en && m_debt >= MP) nurg = 1'b1;

      m_idle = idle ? ((m_idle < PI) ? m_idle + 1 : PI) : 0;
      m_debt = nd;
      m_req  = nreq;
      m_urg  = nurg;
      if (en && m_start < 0) begin
         m_start = cyc;
         m_n     = int'(aref_interval);
      end else if (!en) m_start = -1;
      cyc++;
   endtask

   task automatic step(input bit b, input bit h, input bit a);
      dispatcher_busy = b;
      host_pending    = h;
      autoref_ack     = a;
      @(negedge clk);
      chk("req", int'(autoref_req), int'(m_req));
      chk("urgent", int'(aref_urgent), int'(m_urg));
      chk("debt", int'($signed(aref_debt)), m_debt);
      chk("overflow", int'(aref_overflow), int'(m_ovf));
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_rand(input int n, input int pb, input int ph, input int pa, input int ptog);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < ptog) begin
            if (aref_en) aref_en = 1'b0;
            else begin
               aref_interval = 28'($urandom_range(12, 0));
               aref_en       = 1'b1;
            end
         end
         step($urandom_range(99) < pb, $urandom_range(99) < ph, $urandom_range(99) < pa);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      aref_en = 1'b0;
      dispatcher_busy = 1'b0;
      host_pending = 1'b0;
      autoref_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", int'(autoref_req), 0);
      chk("rst_urgent", int'(aref_urgent), 0);
      chk("rst_debt", int'($signed(aref_debt)), 0);
      chk("rst_overflow", int'(aref_overflow), 0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      do_reset();

      // Basic tick -> debt -> request -> ack sequence with interval 100.
      aref_interval = 28'd100;
      aref_en = 1'b1;
      repeat (110) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b0, 1'b0);

      // Busy dispatcher: debt climbs to urgent, saturates, then overflows.
      do_reset();
      aref_interval = 28'd10;
      aref_en = 1'b1;
      repeat (105) step(1'b1, 1'b0, 1'b0);
      chk("overflow_set", int'(aref_overflow), 1);
      chk("urgent_busy", int'(aref_urgent), 1);
      chk("debt_sat", int'($signed(aref_debt)), MP + 1);

      // Asynchronous reset while URGENT clears outputs without a clock edge.
      #2;
      rst = 1'b1;
      #1;
      chk("arst_req", int'(autoref_req), 0);
      chk("arst_urgent", int'(aref_urgent), 0);
      chk("arst_debt", int'($signed(aref_debt)), 0);
      chk("arst_overflow", int'(aref_overflow), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (25) step(1'b1, 1'b0, 1'b0);

      // Disable with a request pending at debt 2.
      do_reset();
      aref_interval = 28'd10;
      aref_en = 1'b1;
      repeat (21) step(1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      aref_en = 1'b0;
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("dis_req_held", int'(autoref_req), 1);
      chk("dis_debt_clr", int'($signed(aref_debt)), 0);
      step(1'b0, 1'b0, 1'b1);
      repeat (15) step(1'b0, 1'b0, 1'b0);

      // Random traffic, acks and enable/interval changes.
      do_reset();
      aref_interval = 28'd10;
      aref_en = 1'b1;
      run_rand(2000, 20, 20, 30, 1);
      run_rand(1500, 70, 10, 5, 0);

`ifdef AREF_PULLIN_EN
      // Long interval, idle host: pull-in drives debt down to the floor.
      do_reset();
      aref_interval = 28'd1000;
      aref_en = 1'b1;
      run_rand(1600, 0, 0, 40, 0);
      run_rand(1500, 5, 5, 40, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
